// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit RISC CPU: opcodes, sequencer states and the strobe bundle.
package cpu_pkg;

  typedef enum logic [2:0] {
    OpHlt  = 3'b000,
    OpSkz  = 3'b001,
    OpAdd  = 3'b010,
    OpAndd = 3'b011,
    OpXorr = 3'b100,
    OpLda  = 3'b101,
    OpSto  = 3'b110,
    OpJmp  = 3'b111
  } opcode_e;

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StS0   = 4'd1,
    StS1   = 4'd2,
    StS2   = 4'd3,
    StS3   = 4'd4,
    StS4   = 4'd5,
    StS5   = 4'd6,
    StS6   = 4'd7,
    StS7   = 4'd8,
    StHalt = 4'd9
  } state_e;

  typedef struct packed {
    logic load_ir;
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic rd;
    logic wr;
    logic datactl_ena;
    logic alu_c;
    logic halt;
  } ctrl_t;

endpackage

// File: rtl/op_class_dec.sv
// Combinational classification of the latched opcode into instruction classes.
module op_class_dec
  import cpu_pkg::*;
(
  input  logic [2:0] op,
  output logic       is_alu,
  output logic       is_sto,
  output logic       is_jmp,
  output logic       is_skz,
  output logic       is_hlt
);

  opcode_e op_e;
  assign op_e = opcode_e'(op);

  assign is_alu = op_e inside {OpAdd, OpAndd, OpXorr, OpLda};
  assign is_sto = (op_e == OpSto);
  assign is_jmp = (op_e == OpJmp);
  assign is_skz = (op_e == OpSkz);
  assign is_hlt = (op_e == OpHlt);

endmodule

// File: rtl/machine_ctrl.sv
// Instruction sequencer: steps each instruction through S0..S7 and drives registered strobes.
module machine_ctrl
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       load_ir,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       rd,
  output logic       wr,
  output logic       datactl_ena,
  output logic       alu_c,
  output logic       halt,
  output logic [3:0] state_o
);

  state_e  state_q, state_d;
  opcode_e op_q, op_d;
  logic    zero_q, zero_d;
  ctrl_t   ctrl_q, ctrl_d;
  logic    is_alu, is_sto, is_jmp, is_skz, is_hlt;

  op_class_dec u_op_class_dec (
    .op     (op_q),
    .is_alu (is_alu),
    .is_sto (is_sto),
    .is_jmp (is_jmp),
    .is_skz (is_skz),
    .is_hlt (is_hlt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= OpHlt;
      zero_q  <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      zero_q  <= zero_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == StHalt) begin
      state_d = StHalt;
    end else if (!ena) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StS0;
        StS0:    state_d = StS1;
        StS1:    state_d = StS2;
        StS2:    state_d = StS3;
        StS3:    state_d = is_hlt ? StHalt : StS4;
        StS4:    state_d = StS5;
        StS5:    state_d = StS6;
        StS6:    state_d = StS7;
        StS7:    state_d = StS0;
        default: state_d = StIdle;
      endcase
    end
  end

  // Captures only on the real transitions, so aborted instructions leave them untouched.
  always_comb begin
    op_d   = (state_q == StS1 && state_d == StS2) ? opcode_e'(opcode) : op_q;
    zero_d = (state_q == StS4 && state_d == StS5) ? zero : zero_q;
  end

  // Outputs are decoded from the next state so they are high exactly while in that state.
  always_comb begin
    ctrl_d = '0;
    unique case (state_d)
      StS0, StS1: begin
        ctrl_d.rd      = 1'b1;
        ctrl_d.load_ir = 1'b1;
        ctrl_d.inc_pc  = 1'b1;
      end
      StS4: begin
        if (is_alu)      ctrl_d.rd          = 1'b1;
        else if (is_sto) ctrl_d.datactl_ena = 1'b1;
        else if (is_jmp) ctrl_d.load_pc     = 1'b1;
      end
      StS5: begin
        if (is_alu) begin
          ctrl_d.rd    = 1'b1;
          ctrl_d.alu_c = 1'b1;
        end else if (is_sto) begin
          ctrl_d.datactl_ena = 1'b1;
          ctrl_d.wr          = 1'b1;
        end else if (is_jmp) begin
          ctrl_d.load_pc = 1'b1;
        end else if (is_skz) begin
          ctrl_d.inc_pc = zero_d;
        end
      end
      StS6: begin
        if (is_alu) begin
          ctrl_d.rd       = 1'b1;
          ctrl_d.load_acc = 1'b1;
        end else if (is_sto) begin
          ctrl_d.datactl_ena = 1'b1;
        end else if (is_skz) begin
          ctrl_d.inc_pc = zero_d;
        end
      end
      StHalt:  ctrl_d.halt = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  assign load_ir     = ctrl_q.load_ir;
  assign inc_pc      = ctrl_q.inc_pc;
  assign load_pc     = ctrl_q.load_pc;
  assign load_acc    = ctrl_q.load_acc;
  assign rd          = ctrl_q.rd;
  assign wr          = ctrl_q.wr;
  assign datactl_ena = ctrl_q.datactl_ena;
  assign alu_c       = ctrl_q.alu_c;
  assign halt        = ctrl_q.halt;
  assign state_o     = state_q;

endmodule
